// File: rtl/sh_int_accept.sv
// ============================================================================
// Module      : sh_int_accept
// Description : SH7034 CPU-side interrupt acceptance sequencer. Accepts a
//               pending interrupt at an instruction boundary, stacks SR/PC,
//               handshakes the vector and fetches the handler address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sh_int_accept (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    output logic [3:0]  INT_MASK,
    output logic        INT_ACP,
    output logic        INT_ACK,
    output logic        VECT_REQ,
    input  logic        VECT_WAIT,
    input  logic        BOUNDARY,
    input  logic        BLOCK,
    input  logic [31:0] SR_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] SP_IN,
    input  logic [31:0] VBR_IN,
    output logic        EXC_BUSY,
    output logic        EXC_DONE,
    output logic [31:0] NEW_PC,
    output logic [31:0] NEW_SP,
    output logic [3:0]  NEW_SR_I,
    output logic [27:0] BUS_A,
    output logic [31:0] BUS_DO,
    input  logic [31:0] BUS_DI,
    output logic [3:0]  BUS_BA,
    output logic        BUS_WE,
    output logic        BUS_REQ,
    input  logic        BUS_BUSY
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PUSH_SR = 3'd1;
    localparam logic [2:0] c_ST_PUSH_PC = 3'd2;
    localparam logic [2:0] c_ST_VECT    = 3'd3;
    localparam logic [2:0] c_ST_VWAIT   = 3'd4;
    localparam logic [2:0] c_ST_FETCH   = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;
    localparam logic [7:0] c_NMI_VEC    = 8'd11;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [3:0]  r_lvl;
    logic [7:0]  r_vec;
    logic [31:0] r_sr;
    logic [31:0] r_pc;
    logic [31:0] r_sp;
    logic [27:0] r_vbr;
    logic [31:0] r_new_pc;
    logic [3:0]  r_mask;

    logic        w_accept;
    logic        w_bus_state;
    logic        w_bus_done;
    logic [27:0] w_sp_m4;
    logic [27:0] w_sp_m8;
    logic [27:0] w_vec_addr;
    logic        w_unused_vbr;

    // Bus addresses only span 28 bits, so the top VBR nibble never matters.
    assign w_unused_vbr = ^VBR_IN[31:28];

    // Reset overrides an otherwise valid acceptance in the same cycle.
    assign w_accept = (r_state == c_ST_IDLE) && !RST && INT_REQ && BOUNDARY && !BLOCK &&
                      ((INT_LVL > SR_IN[7:4]) || (INT_VEC == c_NMI_VEC));

    assign w_bus_state = (r_state == c_ST_PUSH_SR) || (r_state == c_ST_PUSH_PC) ||
                         (r_state == c_ST_FETCH);
    assign w_bus_done  = w_bus_state && !BUS_BUSY;

    // Modulo-2^28 arithmetic equals 32-bit math truncated to [27:0].
    assign w_sp_m4    = r_sp[27:0] - 28'd4;
    assign w_sp_m8    = r_sp[27:0] - 28'd8;
    assign w_vec_addr = r_vbr + {18'd0, r_vec, 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_accept)   w_state_nxt = c_ST_PUSH_SR;
            c_ST_PUSH_SR: if (w_bus_done) w_state_nxt = c_ST_PUSH_PC;
            c_ST_PUSH_PC: if (w_bus_done) w_state_nxt = c_ST_VECT;
            c_ST_VECT:    w_state_nxt = c_ST_VWAIT;
            c_ST_VWAIT:   if (!VECT_WAIT) w_state_nxt = c_ST_FETCH;
            c_ST_FETCH:   if (w_bus_done) w_state_nxt = c_ST_DONE;
            c_ST_DONE:    w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_ST_IDLE;
            r_lvl    <= 4'd0;
            r_vec    <= 8'd0;
            r_sr     <= 32'd0;
            r_pc     <= 32'd0;
            r_sp     <= 32'd0;
            r_vbr    <= 28'd0;
            r_new_pc <= 32'd0;
            r_mask   <= 4'hF;
        end else begin
            r_state <= w_state_nxt;
            // Full mask while sequencing keeps the controller from re-requesting.
            r_mask  <= (w_state_nxt == c_ST_IDLE) ? SR_IN[7:4] : 4'hF;
            if (w_accept) begin
                r_lvl <= INT_LVL;
                r_vec <= INT_VEC;
                r_sr  <= SR_IN;
                r_pc  <= PC_IN;
                r_sp  <= SP_IN;
                r_vbr <= VBR_IN[27:0];
            end
            if ((r_state == c_ST_FETCH) && !BUS_BUSY) begin
                r_new_pc <= BUS_DI;
            end
        end
    end

    always_comb begin
        INT_MASK = r_mask;
        INT_ACP  = w_accept;
        INT_ACK  = 1'b0;
        VECT_REQ = 1'b0;
        EXC_BUSY = (r_state != c_ST_IDLE) || w_accept;
        EXC_DONE = 1'b0;
        NEW_PC   = 32'd0;
        NEW_SP   = 32'd0;
        NEW_SR_I = 4'd0;
        BUS_A    = 28'd0;
        BUS_DO   = 32'd0;
        BUS_BA   = 4'd0;
        BUS_WE   = 1'b0;
        BUS_REQ  = 1'b0;
        case (r_state)
            c_ST_PUSH_SR: begin
                BUS_REQ = 1'b1;
                BUS_WE  = 1'b1;
                BUS_BA  = 4'hF;
                BUS_A   = w_sp_m4;
                BUS_DO  = r_sr;
            end
            c_ST_PUSH_PC: begin
                BUS_REQ = 1'b1;
                BUS_WE  = 1'b1;
                BUS_BA  = 4'hF;
                BUS_A   = w_sp_m8;
                BUS_DO  = r_pc;
            end
            c_ST_VECT: begin
                VECT_REQ = 1'b1;
                INT_ACK  = 1'b1;
            end
            c_ST_FETCH: begin
                BUS_REQ = 1'b1;
                BUS_BA  = 4'hF;
                BUS_A   = w_vec_addr;
            end
            c_ST_DONE: begin
                EXC_DONE = 1'b1;
                NEW_PC   = r_new_pc;
                NEW_SP   = r_sp - 32'd8;
                NEW_SR_I = (r_vec == c_NMI_VEC) ? 4'hF : r_lvl;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
